// File: rtl/cdb_wb_arbiter_if.sv
// Writeback request/broadcast bundle between the functional units and the CDB arbiter.
// master = functional-unit/consumer side, slave = arbiter side.
interface cdb_wb_arbiter_if #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 5
);
    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0]           req_valid;
    logic [NUM_UNITS-1:0]           req_ready;
    logic [NUM_UNITS*DATA_W-1:0]    req_data;
    logic [NUM_UNITS*ROB_IDX_W-1:0] req_rob_idx;
    logic [NUM_UNITS*5-1:0]         req_rd_addr;
    logic [NUM_UNITS-1:0]           req_br_en;
    logic [NUM_UNITS*DATA_W-1:0]    req_pc_new;

    logic                           cdb_valid;
    logic [UNIT_W-1:0]              cdb_unit;
    logic [DATA_W-1:0]              cdb_data;
    logic [ROB_IDX_W-1:0]           cdb_rob_idx;
    logic [4:0]                     cdb_rd_addr;
    logic                           cdb_br_en;
    logic [DATA_W-1:0]              cdb_pc_new;

    modport master (
        output req_valid, req_data, req_rob_idx, req_rd_addr, req_br_en, req_pc_new,
        input  req_ready,
        input  cdb_valid, cdb_unit, cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en, cdb_pc_new
    );

    modport slave (
        input  req_valid, req_data, req_rob_idx, req_rd_addr, req_br_en, req_pc_new,
        output req_ready,
        output cdb_valid, cdb_unit, cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en, cdb_pc_new
    );
endinterface

// File: rtl/cdb_wb_arbiter.sv
// Round-robin CDB writeback arbiter: one-entry slot per unit, one registered broadcast per cycle, 1 cycle slot->CDB.
// Backpressure: req_ready drops while a slot is full and not granted, and for the whole flush cycle.
module cdb_wb_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    cdb_wb_arbiter_if.slave    bus
);
    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [4:0]           rd_addr;
        logic                 br_en;
        logic [DATA_W-1:0]    pc_new;
    } wb_res_t;

    wb_res_t              slot_d [NUM_UNITS];
    wb_res_t              slot_q [NUM_UNITS];
    logic [NUM_UNITS-1:0] full_q;
    logic [UNIT_W-1:0]    rr_q;

    logic [NUM_UNITS-1:0] grant;
    logic                 grant_vld;
    logic [UNIT_W-1:0]    winner;
    logic [NUM_UNITS-1:0] ready;
    logic [NUM_UNITS-1:0] accept;

    logic                 cdb_valid_q;
    logic [UNIT_W-1:0]    cdb_unit_q;
    wb_res_t              cdb_q;

    function automatic logic [UNIT_W-1:0] wrap_idx(input logic [UNIT_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_UNITS) s = s - NUM_UNITS;
        return UNIT_W'(s);
    endfunction

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
        assign slot_d[g] = {bus.req_data[g*DATA_W +: DATA_W],
                            bus.req_rob_idx[g*ROB_IDX_W +: ROB_IDX_W],
                            bus.req_rd_addr[g*5 +: 5],
                            bus.req_br_en[g],
                            bus.req_pc_new[g*DATA_W +: DATA_W]};
    end

    // Winner depends only on occupancy and rr pointer, so a unit's valid never affects who wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        winner    = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!grant_vld && full_q[wrap_idx(rr_q, k)]) begin
                grant_vld = 1'b1;
                winner    = wrap_idx(rr_q, k);
            end
        end
        if (grant_vld) grant[winner] = 1'b1;
    end

    // A granted slot may be refilled in the same cycle, giving back-to-back streaming.
    assign ready         = flush ? '0 : (~full_q | grant);
    assign accept        = bus.req_valid & ready;
    assign bus.req_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_unit_q  <= '0;
            cdb_q       <= '0;
            for (int i = 0; i < NUM_UNITS; i++) slot_q[i] <= '0;
        end else if (flush) begin
            full_q      <= '0;
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
        end else begin
            cdb_valid_q <= grant_vld;
            if (grant_vld) begin
                cdb_q      <= slot_q[winner];
                cdb_unit_q <= winner;
                rr_q       <= wrap_idx(winner, 1);
            end
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (accept[i]) begin
                    slot_q[i] <= slot_d[i];
                    full_q[i] <= 1'b1;
                end else if (grant[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_unit    = cdb_unit_q;
    assign bus.cdb_data    = cdb_q.data;
    assign bus.cdb_rob_idx = cdb_q.rob_idx;
    assign bus.cdb_rd_addr = cdb_q.rd_addr;
    assign bus.cdb_br_en   = cdb_q.br_en;
    assign bus.cdb_pc_new  = cdb_q.pc_new;
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed bench for the CDB writeback arbiter: inputs driven and outputs sampled 1ns after posedge.
module tb_cdb_wb_arbiter;
    logic clk;
    logic rst_n;
    logic flush;
    int   tests;
    int   fails;

    cdb_wb_arbiter_if #(.NUM_UNITS(4), .DATA_W(32), .ROB_IDX_W(5)) bus ();

    cdb_wb_arbiter #(.NUM_UNITS(4), .DATA_W(32), .ROB_IDX_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req;
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.req_rob_idx = '0;
        bus.req_rd_addr = '0;
        bus.req_br_en   = '0;
        bus.req_pc_new  = '0;
    endtask

    task automatic set_req(input int u, input logic [31:0] d, input logic [4:0] rob,
                           input logic [4:0] rd, input logic br, input logic [31:0] pc);
        bus.req_valid[u]          = 1'b1;
        bus.req_data[u*32 +: 32]  = d;
        bus.req_rob_idx[u*5 +: 5] = rob;
        bus.req_rd_addr[u*5 +: 5] = rd;
        bus.req_br_en[u]          = br;
        bus.req_pc_new[u*32 +: 32] = pc;
    endtask

    // Called 1ns after a posedge: reset pulse sits entirely between edges.
    task automatic do_reset;
        flush = 1'b0;
        clear_req();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        flush = 1'b0;
        clear_req();
        rst_n = 1'b0;
        repeat (2) tick();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL reset_cdb_valid: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
        if (bus.cdb_unit !== 2'd0) begin $display("FAIL reset_cdb_unit: got %0d want 0", bus.cdb_unit); fails++; end
        tests++;
        if ({bus.cdb_data, bus.cdb_pc_new} !== 64'd0) begin
            $display("FAIL reset_cdb_data_pc: got %h/%h want 0/0", bus.cdb_data, bus.cdb_pc_new); fails++;
        end
        tests++;
        if ({bus.cdb_rob_idx, bus.cdb_rd_addr, bus.cdb_br_en} !== 11'd0) begin
            $display("FAIL reset_cdb_idx: got rob %0d rd %0d br %b want 0", bus.cdb_rob_idx, bus.cdb_rd_addr, bus.cdb_br_en); fails++;
        end
        tests++;
        rst_n = 1'b1;
        #1;
        if (bus.req_ready !== 4'b1111) begin $display("FAIL reset_req_ready: got %b want 1111", bus.req_ready); fails++; end
        tests++;
        tick();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL reset_idle_valid: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
    endtask

    task automatic test_single;
        set_req(1, 32'hDEADBEEF, 5'd7, 5'd5, 1'b0, 32'h0000_1000);
        if (bus.req_ready[1] !== 1'b1) begin $display("FAIL single_ready: got %b want 1", bus.req_ready[1]); fails++; end
        tests++;
        tick();
        clear_req();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL single_accept_edge_valid: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
        tick();
        if (bus.cdb_valid !== 1'b1 || bus.cdb_unit !== 2'd1) begin
            $display("FAIL single_bcast: got valid %b unit %0d want 1/1", bus.cdb_valid, bus.cdb_unit); fails++;
        end
        tests++;
        if (bus.cdb_data !== 32'hDEADBEEF || bus.cdb_rob_idx !== 5'd7 || bus.cdb_rd_addr !== 5'd5) begin
            $display("FAIL single_payload: got %h rob %0d rd %0d want deadbeef/7/5", bus.cdb_data, bus.cdb_rob_idx, bus.cdb_rd_addr); fails++;
        end
        tests++;
        tick();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL single_after_valid: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
        if (bus.cdb_data !== 32'hDEADBEEF) begin $display("FAIL single_payload_hold: got %h want deadbeef", bus.cdb_data); fails++; end
        tests++;
    endtask

    task automatic test_all_four;
        do_reset();
        for (int u = 0; u < 4; u++) set_req(u, 32'h100 + u, 5'(10 + u), 5'(u + 1), 1'b0, 32'h0);
        tick();
        clear_req();
        for (int i = 0; i < 4; i++) begin
            // Slots i..3 still full, slot i granted.
            if (bus.req_ready !== 4'((1 << (i + 1)) - 1)) begin
                $display("FAIL all4_ready[%0d]: got %b want %b", i, bus.req_ready, 4'((1 << (i + 1)) - 1)); fails++;
            end
            tests++;
            tick();
            if (bus.cdb_valid !== 1'b1 || bus.cdb_unit !== 2'(i) || bus.cdb_data !== 32'h100 + i) begin
                $display("FAIL all4_bcast[%0d]: got valid %b unit %0d data %h want 1/%0d/%h",
                         i, bus.cdb_valid, bus.cdb_unit, bus.cdb_data, i, 32'h100 + i); fails++;
            end
            tests++;
        end
        if (bus.req_ready !== 4'b1111) begin $display("FAIL all4_ready_end: got %b want 1111", bus.req_ready); fails++; end
        tests++;
        tick();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL all4_drain_valid: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
    endtask

    task automatic test_fairness;
        logic [4:0] rob_seq  [5] = '{5'd20, 5'd21, 5'd22, 5'd22, 5'd23};
        logic       rdy_exp  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       vld_exp  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] unit_exp [5] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
        logic [4:0] rob_exp  [5] = '{5'd0, 5'd20, 5'd30, 5'd21, 5'd22};
        do_reset();
        set_req(2, 32'h2222, 5'd30, 5'd3, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) bus.req_valid[2] = 1'b0;
            set_req(0, 32'h0A00 + 32'(rob_seq[c]), rob_seq[c], 5'd1, 1'b0, 32'h0);
            #1;
            if (bus.req_ready[0] !== rdy_exp[c]) begin
                $display("FAIL fair_ready0[%0d]: got %b want %b", c, bus.req_ready[0], rdy_exp[c]); fails++;
            end
            tests++;
            tick();
            if (bus.cdb_valid !== vld_exp[c]) begin
                $display("FAIL fair_valid[%0d]: got %b want %b", c, bus.cdb_valid, vld_exp[c]); fails++;
            end
            tests++;
            if (vld_exp[c]) begin
                if (bus.cdb_unit !== unit_exp[c] || bus.cdb_rob_idx !== rob_exp[c]) begin
                    $display("FAIL fair_bcast[%0d]: got unit %0d rob %0d want %0d/%0d",
                             c, bus.cdb_unit, bus.cdb_rob_idx, unit_exp[c], rob_exp[c]); fails++;
                end
                tests++;
            end
        end
        clear_req();
        tick();
        if (bus.cdb_valid !== 1'b1 || bus.cdb_unit !== 2'd0 || bus.cdb_rob_idx !== 5'd23) begin
            $display("FAIL fair_last: got valid %b unit %0d rob %0d want 1/0/23", bus.cdb_valid, bus.cdb_unit, bus.cdb_rob_idx); fails++;
        end
        tests++;
        tick();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL fair_drain: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            set_req(3, 32'h3000 + k, 5'(k), 5'd7, 1'b0, 32'h4000 + k);
            #1;
            if (bus.req_ready[3] !== 1'b1) begin $display("FAIL stream_ready3[%0d]: got %b want 1", k, bus.req_ready[3]); fails++; end
            tests++;
            tick();
            if (k > 1) begin
                if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_idx !== 5'(k - 1) || bus.cdb_pc_new !== 32'h4000 + k - 1) begin
                    $display("FAIL stream_bcast[%0d]: got valid %b rob %0d pc %h want 1/%0d/%h",
                             k, bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_pc_new, k - 1, 32'h4000 + k - 1); fails++;
                end
                tests++;
            end
        end
        clear_req();
        tick();
        if (bus.cdb_valid !== 1'b1 || bus.cdb_unit !== 2'd3 || bus.cdb_rob_idx !== 5'd5) begin
            $display("FAIL stream_last: got valid %b unit %0d rob %0d want 1/3/5", bus.cdb_valid, bus.cdb_unit, bus.cdb_rob_idx); fails++;
        end
        tests++;
        tick();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL stream_drain: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
    endtask

    task automatic test_flush;
        do_reset();
        set_req(1, 32'h1111, 5'd1, 5'd1, 1'b0, 32'h0);
        tick();
        clear_req();
        set_req(0, 32'hAAAA, 5'd2, 5'd2, 1'b0, 32'h0);
        set_req(2, 32'hCCCC, 5'd3, 5'd3, 1'b0, 32'h0);
        tick();
        // Unit 1 broadcast, slots 0 and 2 now full, rr pointer at 2.
        clear_req();
        if (bus.cdb_valid !== 1'b1 || bus.cdb_unit !== 2'd1) begin
            $display("FAIL flush_pre_bcast: got valid %b unit %0d want 1/1", bus.cdb_valid, bus.cdb_unit); fails++;
        end
        tests++;
        flush = 1'b1;
        set_req(0, 32'hBAD0, 5'd4, 5'd4, 1'b0, 32'h0);
        #1;
        if (bus.req_ready !== 4'b0000) begin $display("FAIL flush_ready: got %b want 0000", bus.req_ready); fails++; end
        tests++;
        tick();
        flush = 1'b0;
        clear_req();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL flush_valid: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
        set_req(1, 32'h5151, 5'd9, 5'd9, 1'b0, 32'h0);
        set_req(3, 32'h5353, 5'd11, 5'd11, 1'b1, 32'h80);
        #1;
        if (bus.req_ready !== 4'b1111) begin $display("FAIL flush_ready_after: got %b want 1111", bus.req_ready); fails++; end
        tests++;
        tick();
        clear_req();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL flush_no_stale: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
        tick();
        if (bus.cdb_valid !== 1'b1 || bus.cdb_unit !== 2'd1 || bus.cdb_data !== 32'h5151) begin
            $display("FAIL flush_first: got valid %b unit %0d data %h want 1/1/5151", bus.cdb_valid, bus.cdb_unit, bus.cdb_data); fails++;
        end
        tests++;
        tick();
        if (bus.cdb_valid !== 1'b1 || bus.cdb_unit !== 2'd3 || bus.cdb_br_en !== 1'b1 || bus.cdb_pc_new !== 32'h80) begin
            $display("FAIL flush_second: got valid %b unit %0d br %b pc %h want 1/3/1/80",
                     bus.cdb_valid, bus.cdb_unit, bus.cdb_br_en, bus.cdb_pc_new); fails++;
        end
        tests++;
        tick();
        if (bus.cdb_valid !== 1'b0) begin $display("FAIL flush_drain: got %b want 0", bus.cdb_valid); fails++; end
        tests++;
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int u = 0; u < 3; u++) set_req(u, 32'h700 + u, 5'(20 + u), 5'd2, 1'b0, 32'h0);
        tick();
        clear_req();
        tick();
        if (bus.cdb_valid !== 1'b1 || bus.cdb_unit !== 2'd0) begin
            $display("FAIL arst_pre_bcast: got valid %b unit %0d want 1/0", bus.cdb_valid, bus.cdb_unit); fails++;
        end
        tests++;
        #2;
        rst_n = 1'b0;
        #1;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_data !== 32'd0) begin
            $display("FAIL arst_immediate: got valid %b data %h want 0/0", bus.cdb_valid, bus.cdb_data); fails++;
        end
        tests++;
        #1;
        rst_n = 1'b1;
        #1;
        if (bus.req_ready !== 4'b1111) begin $display("FAIL arst_ready: got %b want 1111", bus.req_ready); fails++; end
        tests++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.cdb_valid !== 1'b0) begin $display("FAIL arst_idle[%0d]: got %b want 0", c, bus.cdb_valid); fails++; end
            tests++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        clear_req();
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
